// File: rtl/id_ex_stage_pkg.sv
// Shared widths, EX-stage register layout and helpers for the ID/EX boundary.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package id_ex_stage_pkg;

    localparam int XLEN        = 32;
    localparam int XADDR       = 5;
    localparam int CTRL_W_DFLT = 16;

    // Control bundle value carried by a bubble: every control bit deasserted.
    localparam logic [CTRL_W_DFLT-1:0] BUBBLE_CTRL = '0;

    // Everything EX sees except the opaque control bundle, whose width is a
    // parameter of the stage and so lives in its own register.
    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rs1;
        logic [XLEN-1:0]  rs2;
        logic [XADDR-1:0] rs1_addr;
        logic [XADDR-1:0] rs2_addr;
        logic [XADDR-1:0] rd_addr;
        logic             rd_wr_en;
        logic             mem_rd;
    } ex_state_t;

    // Bubble: nothing valid, nothing written, addresses and data all zero.
    localparam ex_state_t BUBBLE_EX = '0;

    // The regfile is written and read in the same cycle; when WB targets the
    // register being read, take the WB data instead of the stale read.
    // x0 is never bypassed because it is hardwired to zero.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic [XLEN-1:0]  rf_dat,
        input logic [XADDR-1:0] rs_addr,
        input logic [XLEN-1:0]  wb_dat,
        input logic [XADDR-1:0] wb_addr,
        input logic             wb_en
    );
        if (wb_en && (wb_addr != '0) && (wb_addr == rs_addr))
            return wb_dat;
        return rf_dat;
    endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: flags an ID instruction reading the rd of a load in EX.
// Latency: purely combinational, 0 cycles.
// Backpressure: stall_id holds IF/ID; asserted by any external freeze or an unflushed load-use.
// Ports:
//   ex_valid/ex_mem_rd/ex_rd_addr          - state of the instruction currently in EX
//   id_valid/uses_rsN/rsN_addr             - operand usage of the instruction in ID
//   flush/stall_ext                        - redirect and whole-pipe freeze
//   load_use/stall_id                      - raw hazard and resulting ID hold
module id_ex_stage_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic             ex_valid,
    input  logic             ex_mem_rd,
    input  logic [XADDR-1:0] ex_rd_addr,
    input  logic             id_valid,
    input  logic             uses_rs1,
    input  logic [XADDR-1:0] rs1_addr,
    input  logic             uses_rs2,
    input  logic [XADDR-1:0] rs2_addr,
    input  logic             flush,
    input  logic             stall_ext,
    output logic             load_use,
    output logic             stall_id
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit  = uses_rs1 && (rs1_addr == ex_rd_addr);
    assign rs2_hit  = uses_rs2 && (rs2_addr == ex_rd_addr);

    // A load to x0 produces nothing to wait for.
    assign load_use = ex_valid && ex_mem_rd && (ex_rd_addr != '0) && id_valid
                      && (rs1_hit || rs2_hit);

    // A flush kills the ID instruction anyway, so a load-use alone need not hold
    // it; an external freeze always holds.
    assign stall_id = stall_ext || (load_use && !flush);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, operand sanitising and WB bypass.
// Latency: 1 cycle ID->EX; one bubble per load-use, otherwise 1 instruction per cycle.
// Backpressure: o_stall_id holds IF/ID; i_stall_ext freezes EX; i_flush overrides both with a bubble.
// Ports:
//   i_clk, i_rst_n                        - clock, async active-low reset (clears to a bubble at PC 0)
//   i_*_id                                - decoded instruction, operands and usage flags from ID
//   i_rd_wb, i_rd_addr_wb, i_rd_wb_wr_en  - same-cycle regfile write from WB, used as bypass
//   i_flush, i_stall_ext                  - redirect from EX and whole-pipe freeze
//   o_stall_id                            - hold IF and ID this cycle
//   or_*_ex                               - registered, sanitised instruction state for EX
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DFLT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid_id,
    input  logic [XLEN-1:0]   i_pc_id,
    input  logic [XLEN-1:0]   i_imm_id,
    input  logic [XLEN-1:0]   i_rs1_id,
    input  logic [XLEN-1:0]   i_rs2_id,
    input  logic [XADDR-1:0]  i_rs1_addr_id,
    input  logic [XADDR-1:0]  i_rs2_addr_id,
    input  logic              i_uses_rs1_id,
    input  logic              i_uses_rs2_id,
    input  logic [XADDR-1:0]  i_rd_addr_id,
    input  logic              i_rd_wr_en_id,
    input  logic              i_mem_rd_id,
    input  logic [CTRL_W-1:0] i_ctrl_id,
    input  logic [XLEN-1:0]   i_rd_wb,
    input  logic [XADDR-1:0]  i_rd_addr_wb,
    input  logic              i_rd_wb_wr_en,
    input  logic              i_flush,
    input  logic              i_stall_ext,
    output logic              o_stall_id,
    output logic              or_valid_ex,
    output logic [XLEN-1:0]   or_pc_ex,
    output logic [XLEN-1:0]   or_imm_ex,
    output logic [XLEN-1:0]   or_rs1_ex,
    output logic [XLEN-1:0]   or_rs2_ex,
    output logic [XADDR-1:0]  or_rs1_addr_ex,
    output logic [XADDR-1:0]  or_rs2_addr_ex,
    output logic [XADDR-1:0]  or_rd_addr_ex,
    output logic              or_rd_wr_en_ex,
    output logic              or_mem_rd_ex,
    output logic [CTRL_W-1:0] or_ctrl_ex
);

    ex_state_t         ex_q;
    ex_state_t         cap;
    logic [CTRL_W-1:0] ctrl_q;
    logic [CTRL_W-1:0] cap_ctrl;
    logic              load_use;

    id_ex_stage_hazard_detect u_hazard (
        .ex_valid   (ex_q.valid),
        .ex_mem_rd  (ex_q.mem_rd),
        .ex_rd_addr (ex_q.rd_addr),
        .id_valid   (i_valid_id),
        .uses_rs1   (i_uses_rs1_id),
        .rs1_addr   (i_rs1_addr_id),
        .uses_rs2   (i_uses_rs2_id),
        .rs2_addr   (i_rs2_addr_id),
        .flush      (i_flush),
        .stall_ext  (i_stall_ext),
        .load_use   (load_use),
        .stall_id   (o_stall_id)
    );

    // Value EX would take on a normal advance. Unused operand indices are
    // zeroed so the forwarding unit never matches on garbage register fields,
    // and a write to x0 is dropped here rather than downstream.
    always_comb begin
        cap      = BUBBLE_EX;
        cap_ctrl = '0;
        if (i_valid_id) begin
            cap.valid    = 1'b1;
            cap.pc       = i_pc_id;
            cap.imm      = i_imm_id;
            cap.rs1      = wb_bypass(i_rs1_id, i_rs1_addr_id, i_rd_wb, i_rd_addr_wb, i_rd_wb_wr_en);
            cap.rs2      = wb_bypass(i_rs2_id, i_rs2_addr_id, i_rd_wb, i_rd_addr_wb, i_rd_wb_wr_en);
            cap.rs1_addr = i_uses_rs1_id ? i_rs1_addr_id : '0;
            cap.rs2_addr = i_uses_rs2_id ? i_rs2_addr_id : '0;
            cap.rd_addr  = i_rd_addr_id;
            cap.rd_wr_en = i_rd_wr_en_id && (i_rd_addr_id != '0);
            cap.mem_rd   = i_mem_rd_id;
            cap_ctrl     = i_ctrl_id;
        end
    end

    // Flush outranks the freeze so a redirect is never lost while memory waits.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ex_q   <= BUBBLE_EX;
            ctrl_q <= '0;
        end else if (i_flush) begin
            ex_q   <= BUBBLE_EX;
            ctrl_q <= '0;
        end else if (i_stall_ext) begin
            ex_q   <= ex_q;
            ctrl_q <= ctrl_q;
        end else if (load_use) begin
            ex_q   <= BUBBLE_EX;
            ctrl_q <= '0;
        end else begin
            ex_q   <= cap;
            ctrl_q <= cap_ctrl;
        end
    end

    assign or_valid_ex    = ex_q.valid;
    assign or_pc_ex       = ex_q.pc;
    assign or_imm_ex      = ex_q.imm;
    assign or_rs1_ex      = ex_q.rs1;
    assign or_rs2_ex      = ex_q.rs2;
    assign or_rs1_addr_ex = ex_q.rs1_addr;
    assign or_rs2_addr_ex = ex_q.rs2_addr;
    assign or_rd_addr_ex  = ex_q.rd_addr;
    assign or_rd_wr_en_ex = ex_q.rd_wr_en;
    assign or_mem_rd_ex   = ex_q.mem_rd;
    assign or_ctrl_ex     = ctrl_q;

endmodule
